// File: rtl/audio_playback_ctrl_pkg.sv
// Shared definitions for the audio playback controller: controller states,
// sample word width and serializer phase constants.
package audio_playback_ctrl_pkg;

  localparam int WORD_W  = 16;
  localparam int PHASE_W = 4;

  localparam logic [PHASE_W-1:0] PHASE_LAST = 4'd15;
  // The serializer reports its word boundary one cycle after the word is loaded.
  localparam logic [PHASE_W-1:0] PHASE_SYNC = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

endpackage

// File: rtl/audio_playback_ctrl_if.sv
// Sample-memory read port and serializer port of the playback controller.
// The master side is the controller; the slave side is memory plus serializer.
interface audio_playback_ctrl_if
  import audio_playback_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [WORD_W-1:0] mem_data_i;
  logic              ser_enable;
  logic [WORD_W-1:0] ser_data_o;
  logic              ser_done;

  modport master (
    output mem_addr, mem_rd_en, ser_enable, ser_data_o,
    input  mem_data_i, ser_done
  );

  modport slave (
    input  mem_addr, mem_rd_en, ser_enable, ser_data_o,
    output mem_data_i, ser_done
  );

endinterface

// File: rtl/playback_addr_gen.sv
// Address sequencing for the playback range: increment modulo 2^ADDR_W,
// end-of-range detection and wrap back to the range start when looping.
module playback_addr_gen #(
  parameter int ADDR_W = 17
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              loop,
  output logic [ADDR_W-1:0] next_addr,
  output logic              has_next
);

  logic is_last;

  assign is_last   = (cur_addr == end_addr);
  assign has_next  = !is_last || loop;
  assign next_addr = is_last ? start_addr : cur_addr + ADDR_W'(1);

endmodule

// File: rtl/audio_playback_ctrl.sv
// Streams an inclusive range of 16-bit sample words from memory into a
// 16-cycle serializer, prefetching each next word while the current one plays.
module audio_playback_ctrl
  import audio_playback_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  play,
  input  logic                  stop,
  input  logic                  loop,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  audio_playback_ctrl_if.master bus,
  output logic                  busy,
  output logic                  play_done,
  output logic                  sync_err
);

  localparam logic [PHASE_W-1:0] LAT = PHASE_W'(RD_LAT);

  state_t state, state_next;

  logic [ADDR_W-1:0]  start_q;
  logic [ADDR_W-1:0]  end_q;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd_en;
  logic               ser_enable;
  logic [WORD_W-1:0]  ser_data;
  logic [WORD_W-1:0]  next_word;
  logic               have_next;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] prime_cnt;
  logic               done_pulse;
  logic               err_flag;

  logic [ADDR_W-1:0]  gen_next_addr;
  logic               gen_has_next;

  logic accept, prime_done, word_end, finish, abort, fetch;

  // mem_addr always holds the most recently fetched word, so it drives the
  // sequencer directly at each fetch decision.
  playback_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .cur_addr   (mem_addr),
    .start_addr (start_q),
    .end_addr   (end_q),
    .loop       (loop),
    .next_addr  (gen_next_addr),
    .has_next   (gen_has_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    prime_done = 1'b0;
    word_end   = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (play) begin
          accept     = 1'b1;
          state_next = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (stop) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (prime_cnt == LAT) begin
          prime_done = 1'b1;
          state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (phase == PHASE_LAST) begin
          if (have_next) begin
            word_end = 1'b1;
          end else begin
            finish     = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Every edge that starts a new word is also the fetch decision for the word after it.
  assign fetch = prime_done || word_end;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_q    <= '0;
      end_q      <= '0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      ser_enable <= 1'b0;
      ser_data   <= '0;
      next_word  <= '0;
      have_next  <= 1'b0;
      phase      <= '0;
      prime_cnt  <= '0;
      done_pulse <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      mem_rd_en  <= 1'b0;
      done_pulse <= 1'b0;

      if (accept) begin
        start_q   <= start_addr;
        end_q     <= end_addr;
        mem_addr  <= start_addr;
        mem_rd_en <= 1'b1;
        prime_cnt <= '0;
      end

      if (state == ST_PRIME) prime_cnt <= prime_cnt + PHASE_W'(1);

      if (state == ST_PLAY) begin
        phase <= phase + PHASE_W'(1);
        if (have_next && (phase == LAT)) next_word <= bus.mem_data_i;
        if (bus.ser_done && (phase != PHASE_SYNC)) err_flag <= 1'b1;
      end

      if (fetch) begin
        have_next <= gen_has_next;
        if (gen_has_next) begin
          mem_addr  <= gen_next_addr;
          mem_rd_en <= 1'b1;
        end
      end

      if (prime_done) ser_data <= bus.mem_data_i;
      if (word_end)   ser_data <= next_word;
      if (fetch) begin
        ser_enable <= 1'b1;
        phase      <= '0;
      end

      if (finish || abort) begin
        ser_enable <= 1'b0;
        ser_data   <= '0;
        mem_rd_en  <= 1'b0;
        have_next  <= 1'b0;
        phase      <= '0;
      end
      if (finish) done_pulse <= 1'b1;
    end
  end

  assign bus.mem_addr   = mem_addr;
  assign bus.mem_rd_en  = mem_rd_en;
  assign bus.ser_enable = ser_enable;
  assign bus.ser_data_o = ser_data;

  assign busy      = (state != ST_IDLE);
  assign play_done = done_pulse;
  assign sync_err  = err_flag;

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Scoreboard bench for audio_playback_ctrl: a stimulus process queues the
// words each playback should produce, a monitor pops them at word boundaries.
module tb_audio_playback_ctrl;
  import audio_playback_ctrl_pkg::*;

  localparam int ADDR_W = 17;
  localparam int RD_LAT = 1;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              play = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic              busy, play_done, sync_err;

  always #5 clock = ~clock;

  audio_playback_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  audio_playback_ctrl #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .play       (play),
    .stop       (stop),
    .loop       (loop),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .bus        (bus),
    .busy       (busy),
    .play_done  (play_done),
    .sync_err   (sync_err)
  );

  // Memory content is a hash of the address, so any address slip shows up as wrong data.
  logic [15:0] salt = 16'h1234;

  function automatic logic [15:0] word_of(input logic [ADDR_W-1:0] a, input logic [15:0] s);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1;
    return h[31:16] ^ h[15:0] ^ s;
  endfunction

  logic [ADDR_W-1:0] lat_addr [RD_LAT];
  logic              lat_vld  [RD_LAT];

  always @(posedge clock) begin
    lat_vld[0]  <= bus.mem_rd_en;
    lat_addr[0] <= bus.mem_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      lat_vld[i]  <= lat_vld[i-1];
      lat_addr[i] <= lat_addr[i-1];
    end
  end

  assign bus.mem_data_i = lat_vld[RD_LAT-1] ? word_of(lat_addr[RD_LAT-1], salt) : 16'hDEAD;

  initial bus.ser_done = 1'b0;

  typedef struct packed {
    logic        is_done;
    logic [15:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Monitor: every 16th enabled cycle is a word boundary; play_done consumes an end marker.
  int          run_cnt  = 0;
  logic [15:0] cur_word = '0;
  exp_t        mon_e;

  always @(negedge clock) begin
    if (!reset_n) begin
      run_cnt = 0;
    end else begin
      if (play_done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_in_order", 32'(mon_e.is_done), 32'd1);
        end
        check("done_enable_low", 32'(bus.ser_enable), 32'd0);
      end
      if (bus.ser_enable) begin
        if (run_cnt % 16 == 0) begin
          if (exp_q.size() == 0) begin
            check("word_unexpected", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("word_not_end", 32'(mon_e.is_done), 32'd0);
            check("word_data", 32'(bus.ser_data_o), 32'(mon_e.word));
            cur_word = mon_e.word;
          end
        end else if (run_cnt % 16 == 15) begin
          check("word_stable", 32'(bus.ser_data_o), 32'(cur_word));
        end
        run_cnt++;
      end else begin
        run_cnt = 0;
      end
    end
  end

  // Reference model: the range length is (end - start) mod 2^ADDR_W + 1.
  task automatic push_range(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                            input bit looped, input int k);
    logic [ADDR_W-1:0] d;
    int                len;
    d   = e - s;
    len = int'(d) + 1;
    if (!looped) begin
      for (int i = 0; i < len; i++) exp_q.push_back('{1'b0, word_of(s + ADDR_W'(i), salt)});
      exp_q.push_back('{1'b1, 16'h0});
    end else begin
      for (int i = 0; i < k; i++) exp_q.push_back('{1'b0, word_of(s + ADDR_W'(i % len), salt)});
    end
  endtask

  int en_seen = 0;

  task automatic wait_en(input int target);
    int budget;
    budget = 2000;
    while (en_seen < target && budget > 0) begin
      @(negedge clock);
      budget--;
      if (bus.ser_enable) en_seen++;
    end
    if (en_seen < target) check("wait_enable_timeout", 32'(en_seen), 32'(target));
  endtask

  task automatic start_play(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e, input bit lp);
    @(negedge clock);
    start_addr = s;
    end_addr   = e;
    loop       = lp;
    play       = 1'b1;
    @(posedge clock);
    #1;
    check("first_strobe", 32'(bus.mem_rd_en), 32'd1);
    check("first_addr", 32'(bus.mem_addr), 32'(s));
    check("busy_on", 32'(busy), 32'd1);
    @(negedge clock);
    play = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      @(posedge clock);
      #1;
      check("prime_enable_low", 32'(bus.ser_enable), 32'd0);
      if (i == 0) check("strobe_one_cycle", 32'(bus.mem_rd_en), 32'd0);
    end
    @(posedge clock);
    #1;
    check("enable_after_prime", 32'(bus.ser_enable), 32'd1);
    en_seen = 0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 3000;
    while (busy && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    @(negedge clock);
    check("idle_reached", 32'(busy), 32'd0);
    check("idle_enable", 32'(bus.ser_enable), 32'd0);
    check("idle_strobe", 32'(bus.mem_rd_en), 32'd0);
    check("idle_data", 32'(bus.ser_data_o), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stop_now();
    stop = 1'b1;
    @(posedge clock);
    #1;
    check("stop_enable", 32'(bus.ser_enable), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_data", 32'(bus.ser_data_o), 32'd0);
    check("stop_strobe", 32'(bus.mem_rd_en), 32'd0);
    check("stop_no_done", 32'(play_done), 32'd0);
    @(negedge clock);
    stop = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] s, e;
    int                len, k, p;

    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_enable", 32'(bus.ser_enable), 32'd0);
    check("reset_data", 32'(bus.ser_data_o), 32'd0);
    check("reset_strobe", 32'(bus.mem_rd_en), 32'd0);
    check("reset_sync_err", 32'(sync_err), 32'd0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;

    // Single word, start == end.
    push_range(17'h10, 17'h10, 1'b0, 0);
    start_play(17'h10, 17'h10, 1'b0);
    wait_idle();

    // Three-word range, with a correctly phased ser_done.
    salt = 16'hA5C3;
    push_range(17'h0, 17'h2, 1'b0, 0);
    start_play(17'h0, 17'h2, 1'b0);
    wait_en(2);
    bus.ser_done = 1'b1;
    wait_en(3);
    bus.ser_done = 1'b0;
    check("sync_ok_phase1", 32'(sync_err), 32'd0);
    wait_idle();

    // Looping 5..6, loop dropped during the fifth word.
    for (int i = 0; i < 6; i++) exp_q.push_back('{1'b0, word_of(17'h5 + 17'(i % 2), salt)});
    exp_q.push_back('{1'b1, 16'h0});
    start_play(17'h5, 17'h6, 1'b1);
    wait_en(70);
    loop = 1'b0;
    wait_idle();

    // Stop at phase 15 of the second word; a play during playback is ignored.
    s = 17'(($urandom % 32'h1_0000) + 32'h100);
    push_range(s, s + 17'd1, 1'b1, 2);
    start_play(s, s + 17'd1, 1'b1);
    wait_en(10);
    start_addr = 17'h3;
    end_addr   = 17'h3;
    play       = 1'b1;
    wait_en(11);
    play = 1'b0;
    wait_en(32);
    stop_now();
    wait_idle();

    // Wrap-around through the top of the address space, ser_done out of phase.
    salt = 16'h0F0F;
    s = 17'h1FFFE;
    e = 17'h00001;
    push_range(s, e, 1'b0, 0);
    start_play(s, e, 1'b0);
    wait_en(6);
    bus.ser_done = 1'b1;
    wait_en(7);
    bus.ser_done = 1'b0;
    check("sync_err_set", 32'(sync_err), 32'd1);
    wait_idle();
    check("sync_err_sticky", 32'(sync_err), 32'd1);

    // Stop while priming.
    @(negedge clock);
    start_addr = 17'h40;
    end_addr   = 17'h44;
    loop       = 1'b0;
    play       = 1'b1;
    @(negedge clock);
    play = 1'b0;
    stop_now();
    wait_idle();

    // Randomised ranges: either played to the end, or looped and stopped mid-word.
    for (int n = 0; n < 12; n++) begin
      salt = 16'($urandom);
      s = 17'($urandom);
      if ($urandom_range(0, 3) == 0) s = 17'h1FFFF - 17'($urandom_range(0, 2));
      len = int'($urandom_range(1, 4));
      e = s + 17'(len - 1);
      if ($urandom_range(0, 1) == 0) begin
        push_range(s, e, 1'b0, 0);
        start_play(s, e, 1'b0);
        wait_idle();
      end else begin
        k = int'($urandom_range(1, 5));
        p = int'($urandom_range(0, 15));
        push_range(s, e, 1'b1, k);
        start_play(s, e, 1'b1);
        wait_en(16 * (k - 1) + p + 1);
        stop_now();
        wait_idle();
      end
    end

    // Asynchronous reset at phase 7: outputs clear at once, no play_done.
    s = 17'h2345;
    push_range(s, s + 17'd1, 1'b0, 0);
    start_play(s, s + 17'd1, 1'b0);
    wait_en(8);
    #1 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_enable", 32'(bus.ser_enable), 32'd0);
    check("arst_data", 32'(bus.ser_data_o), 32'd0);
    check("arst_strobe", 32'(bus.mem_rd_en), 32'd0);
    check("arst_addr", 32'(bus.mem_addr), 32'd0);
    check("arst_done", 32'(play_done), 32'd0);
    check("arst_sync_err", 32'(sync_err), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (20) @(negedge clock);
    check("post_reset_idle", 32'(busy), 32'd0);

    // Normal playback after reset.
    push_range(17'h77, 17'h78, 1'b0, 0);
    start_play(17'h77, 17'h78, 1'b0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
